// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   - SEG_0 .. SEG_F : segment patterns, bit0=a .. bit6=g, active-high
//   - hex_to_seg()   : hex nibble to segment pattern
//   - scan_phase_t   : per-slot phase (BLANK, SHOW)
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_phase_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decoder.sv
// seg7_hex_decoder: combinational hex nibble to 7-segment pattern.
//   hex [3:0] in  : nibble to display
//   seg [6:0] out : segments, bit0=a .. bit6=g, active-high
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-cathode 7-segment scanner.
// Rotating one-hot digit ring advanced by a slot prescaler; each slot opens
// with a short blank to suppress ghosting. Hex words arrive on a valid/ready
// port into a one-deep pending buffer and are copied to the display register
// only at the frame boundary, so a frame never mixes old and new digits.
// Optional feature: define SEG7_DP_EN to add per-digit decimal points.
// Ports:
//   Clock       in   rising-edge clock
//   Reset       in   synchronous, active-high
//   Load_valid  in   Load_data valid
//   Load_ready  out  pending buffer empty
//   Load_data   in   4*NUM_DIGITS hex nibbles, [3:0] = digit0
//   Load_dp     in   NUM_DIGITS dp bits (SEG7_DP_EN only)
//   Seg_dp      out  decimal point of active digit (SEG7_DP_EN only)
//   Digit_en    out  one-hot digit enable, 0 while blanking
//   Seg_out     out  segments, bit0=a .. bit6=g
//   Frame_done  out  pulse on last cycle of last digit slot
//
// Slot phase (decoded from presc):
//   phase | meaning
//   BLANK | presc < BLANK_CYCLES, all digits and segments off
//   SHOW  | active digit enabled with its decoded nibble
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
)
(
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Load_valid,
    output logic                      Load_ready,
    input  logic [4*NUM_DIGITS-1:0]   Load_data,
`ifdef SEG7_DP_EN
    input  logic [NUM_DIGITS-1:0]     Load_dp,
    output logic                      Seg_dp,
`endif
    output logic [NUM_DIGITS-1:0]     Digit_en,
    output logic [6:0]                Seg_out,
    output logic                      Frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

    logic [NUM_DIGITS-1:0]   ring;
    logic [PW-1:0]           presc;
    logic [4*NUM_DIGITS-1:0] disp_reg;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic                    pend_full;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    active_dp;
`endif

    logic        presc_last;
    logic        boundary;
    logic        load_fire;
    scan_phase_t phase;
    logic [3:0]  active_nib;
    logic [6:0]  seg_dec;

    assign presc_last = (presc == PRESC_LAST);
    assign boundary   = presc_last & ring[NUM_DIGITS-1];
    assign load_fire  = Load_valid & ~pend_full;
    assign phase      = (presc < BLANK_END) ? BLANK : SHOW;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ring      <= NUM_DIGITS'(1);
            presc     <= '0;
            disp_reg  <= '0;
            pend_reg  <= '0;
            pend_full <= 1'b0;
`ifdef SEG7_DP_EN
            disp_dp   <= '0;
            pend_dp   <= '0;
`endif
        end else begin
            if (presc_last) begin
                presc <= '0;
                ring  <= {ring[NUM_DIGITS-2:0], ring[NUM_DIGITS-1]};
            end else begin
                presc <= presc + 1'b1;
            end

            // Transfer and accept are exclusive: ready is low whenever a
            // word is pending, so a boundary load always lands in pend_reg.
            if (boundary && pend_full) begin
                disp_reg  <= pend_reg;
                pend_full <= 1'b0;
`ifdef SEG7_DP_EN
                disp_dp   <= pend_dp;
`endif
            end else if (load_fire) begin
                pend_reg  <= Load_data;
                pend_full <= 1'b1;
`ifdef SEG7_DP_EN
                pend_dp   <= Load_dp;
`endif
            end
        end
    end

    always_comb begin
        active_nib = '0;
`ifdef SEG7_DP_EN
        active_dp  = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ring[i]) begin
                active_nib = disp_reg[4*i +: 4];
`ifdef SEG7_DP_EN
                active_dp  = disp_dp[i];
`endif
            end
        end
    end

    seg7_hex_decoder u_dec (
        .hex (active_nib),
        .seg (seg_dec)
    );

    // Outputs are forced quiet while Reset is high so the pins are defined
    // even before the first reset edge has cleared the state.
    always_comb begin
        Load_ready = 1'b1;
        Frame_done = 1'b0;
        Digit_en   = '0;
        Seg_out    = '0;
`ifdef SEG7_DP_EN
        Seg_dp     = 1'b0;
`endif
        if (!Reset) begin
            Load_ready = ~pend_full;
            Frame_done = boundary;
            if (phase == SHOW) begin
                Digit_en = ring;
                Seg_out  = seg_dec;
`ifdef SEG7_DP_EN
                Seg_dp   = active_dp;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int P = 4;
    localparam int B = 1;
    localparam int F = N * P;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Load_valid;
    logic          Load_ready;
    logic [4*N-1:0] Load_data;
    logic [N-1:0]  Load_dp;
    logic [N-1:0]  Digit_en;
    logic [6:0]    Seg_out;
    logic          Frame_done;
`ifdef SEG7_DP_EN
    logic          Seg_dp;
`endif

    seg7_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Load_valid (Load_valid),
        .Load_ready (Load_ready),
        .Load_data  (Load_data),
`ifdef SEG7_DP_EN
        .Load_dp    (Load_dp),
        .Seg_dp     (Seg_dp),
`endif
        .Digit_en   (Digit_en),
        .Seg_out    (Seg_out),
        .Frame_done (Frame_done)
    );

    always #5 Clock = ~Clock;

    // Reference: segment table from the hex glyph definitions.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int             frame;
        logic [4*N-1:0] word;
        logic [N-1:0]   dp;
    } sb_entry_t;

    sb_entry_t      sb_q[$];
    int             t;
    int             ready_at;
    logic [4*N-1:0] disp_m;
    logic [N-1:0]   dp_m;
    bit             holding;
    bit             run;
    int             errors;
    int             checks;

    always @(posedge Clock) t <= Reset ? 0 : t + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
        end
    endtask

    // Monitor: display model derived from cycle position and the frame in
    // which each accepted word becomes visible.
    always @(negedge Clock) begin
        if (run) begin
            if (Reset) begin
                check("rst_digit_en", 32'(Digit_en), 32'h0);
                check("rst_seg", 32'(Seg_out), 32'h0);
                check("rst_ready", 32'(Load_ready), 32'h1);
                check("rst_frame_done", 32'(Frame_done), 32'h0);
`ifdef SEG7_DP_EN
                check("rst_seg_dp", 32'(Seg_dp), 32'h0);
`endif
            end else begin
                int pos, slot;
                logic [N-1:0] exp_en;
                logic [6:0]   exp_seg;
                logic         exp_dp;
                while (sb_q.size() > 0 && sb_q[0].frame <= t / F) begin
                    disp_m = sb_q[0].word;
                    dp_m   = sb_q[0].dp;
                    void'(sb_q.pop_front());
                end
                pos  = t % P;
                slot = (t / P) % N;
                if (pos < B) begin
                    exp_en  = '0;
                    exp_seg = '0;
                    exp_dp  = 1'b0;
                end else begin
                    exp_en  = N'(1) << slot;
                    exp_seg = seg_tab[(disp_m >> (4 * slot)) & 4'hF];
                    exp_dp  = dp_m[slot];
                end
                check("digit_en", 32'(Digit_en), 32'(exp_en));
                check("seg_out", 32'(Seg_out), 32'(exp_seg));
                check("frame_done", 32'(Frame_done), 32'((pos == P - 1) && (slot == N - 1)));
                check("load_ready", 32'(Load_ready), 32'(t >= ready_at));
`ifdef SEG7_DP_EN
                check("seg_dp", 32'(Seg_dp), 32'(exp_dp));
`else
                if (exp_dp === 1'bx) $display("dp model undefined");
`endif
            end
        end
    end

    // One clock: record a handshake against the model's ready, then move
    // input drive 1 time unit past the edge.
    task automatic step();
        @(posedge Clock);
        if (!Reset && Load_valid && (t >= ready_at)) begin
            sb_q.push_back('{frame: (t + 1) / F + 1, word: Load_data, dp: Load_dp});
            ready_at = ((t + 1) / F) * F + F;
            holding  = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        Reset      = 1'b1;
        Load_valid = 1'b0;
        holding    = 1'b0;
        sb_q.delete();
        disp_m     = '0;
        dp_m       = '0;
        ready_at   = 0;
        repeat (cycles) step();
        Reset = 1'b0;
    endtask

    initial begin
        int resets;
        errors = 0; checks = 0; resets = 0;
        Reset = 1'b1; Load_valid = 1'b0; Load_data = '0; Load_dp = '0;
        holding = 1'b0; disp_m = '0; dp_m = '0; ready_at = 0; t = 0;
        run = 1'b1;
        do_reset(2);

        // Directed: first frame blank display, load at c2, stalled load from c3.
        repeat (2) step();
        Load_valid = 1'b1; Load_data = 16'h1234; Load_dp = 4'b0101; holding = 1'b1;
        step();
        Load_data = 16'hBEEF; Load_dp = 4'b1010; holding = 1'b1;
        for (int i = 0; i < 3 * F && holding; i++) step();
        Load_valid = 1'b0;
        while (t != 41) step();
        Load_valid = 1'b1; Load_data = 16'h9A0C; Load_dp = 4'b0011; holding = 1'b1;
        for (int i = 0; i < 3 * F && holding; i++) step();
        Load_valid = 1'b0;
        // Mid-frame reset with a word pending, then watch a full blank frame.
        while (t % F != 9) step();
        Load_valid = 1'b1; Load_data = 16'h5678; holding = 1'b1;
        step();
        Load_valid = 1'b0;
        do_reset(1);
        repeat (F + 4) step();

        // Randomized traffic with occasional mid-frame resets.
        for (int i = 0; i < 1500; i++) begin
            if (!holding) begin
                Load_valid = 1'b0;
                if ($urandom_range(0, 5) == 0) begin
                    Load_data  = 16'($urandom);
                    Load_dp    = 4'($urandom);
                    Load_valid = 1'b1;
                    holding    = 1'b1;
                end
            end
            if (resets < 4 && i > 200 * (resets + 1) && t < ready_at && t % F == 9) begin
                resets++;
                do_reset($urandom_range(1, 3));
            end else begin
                step();
            end
        end
        Load_valid = 1'b0;
        repeat (2 * F) step();

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
